// File: rtl/dispatch_sequencer.sv
// Dispatch sequencer: buffers one decoded instruction group and issues its valid
// slots one per handshake, oldest (lowest index) first, each stamped with a rolling tag.
module dispatch_sequencer #(
  parameter int IPC          = 4,
  parameter int OPCODE_WIDTH = 7,
  parameter int RF_WIDTH     = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int EXEC_WIDTH   = 4,
  parameter int TAG_WIDTH    = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         grp_valid,
  output logic                         grp_ready,
  input  logic [IPC-1:0]               grp_slot_valid,
  input  logic [IPC*OPCODE_WIDTH-1:0]  grp_opcode,
  input  logic [IPC*RF_WIDTH-1:0]      grp_rs1,
  input  logic [IPC*RF_WIDTH-1:0]      grp_rs2,
  input  logic [IPC*RF_WIDTH-1:0]      grp_rd,
  input  logic [IPC*DATA_WIDTH-1:0]    grp_imm,
  input  logic [IPC*EXEC_WIDTH-1:0]    grp_exec,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [((IPC > 1) ? $clog2(IPC) : 1)-1:0] iss_slot,
  output logic [OPCODE_WIDTH-1:0]      iss_opcode,
  output logic [RF_WIDTH-1:0]          iss_rs1,
  output logic [RF_WIDTH-1:0]          iss_rs2,
  output logic [RF_WIDTH-1:0]          iss_rd,
  output logic [DATA_WIDTH-1:0]        iss_imm,
  output logic [EXEC_WIDTH-1:0]        iss_exec,
  output logic [TAG_WIDTH-1:0]         iss_tag,
  output logic [15:0]                  stall_cnt
);

  localparam int SLOT_W = (IPC > 1) ? $clog2(IPC) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state, state_next;
  logic [IPC-1:0]       mask;
  logic [IPC-1:0]       remaining;
  logic [SLOT_W-1:0]    sel;
  logic [TAG_WIDTH-1:0] tag;
  logic                 capture;
  logic                 fire;

  logic [OPCODE_WIDTH-1:0] opcode_q [IPC];
  logic [RF_WIDTH-1:0]     rs1_q    [IPC];
  logic [RF_WIDTH-1:0]     rs2_q    [IPC];
  logic [RF_WIDTH-1:0]     rd_q     [IPC];
  logic [DATA_WIDTH-1:0]   imm_q    [IPC];
  logic [EXEC_WIDTH-1:0]   exec_q   [IPC];

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grp_ready  = (state == IDLE)  && !rst && !flush;
    iss_valid  = (state == ISSUE) && !rst && !flush;
    capture    = grp_valid && grp_ready;
    fire       = iss_valid && iss_ready;
    sel        = '0;
    for (int i = IPC - 1; i >= 0; i--) begin
      if (mask[i]) sel = SLOT_W'(i);
    end
    remaining  = mask & ~(IPC'(1) << sel);
    state_next = state;
    case (state)
      IDLE:    if (capture && (grp_slot_valid != '0)) state_next = ISSUE;
      ISSUE:   if (fire && (remaining == '0))          state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask      <= '0;
      tag       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        mask <= '0;
      end else if (capture) begin
        mask <= grp_slot_valid;
      end else if (fire) begin
        mask[sel] <= 1'b0;
        tag       <= tag + TAG_WIDTH'(1);
      end
      if (iss_valid && !iss_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // NOTE: the slot payload storage is deliberately not reset; it is only read
  // behind a nonzero mask, and skipping reset keeps these as plain flops.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < IPC; i++) begin
        opcode_q[i] <= grp_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        rs1_q[i]    <= grp_rs1[i*RF_WIDTH +: RF_WIDTH];
        rs2_q[i]    <= grp_rs2[i*RF_WIDTH +: RF_WIDTH];
        rd_q[i]     <= grp_rd[i*RF_WIDTH +: RF_WIDTH];
        imm_q[i]    <= grp_imm[i*DATA_WIDTH +: DATA_WIDTH];
        exec_q[i]   <= grp_exec[i*EXEC_WIDTH +: EXEC_WIDTH];
      end
    end
  end

  // Outputs are zeroed when not offering so consumers never see stale slots.
  always_comb begin
    iss_slot   = '0;
    iss_tag    = '0;
    iss_opcode = '0;
    iss_rs1    = '0;
    iss_rs2    = '0;
    iss_rd     = '0;
    iss_imm    = '0;
    iss_exec   = '0;
    if (iss_valid) begin
      iss_slot   = sel;
      iss_tag    = tag;
      iss_opcode = opcode_q[sel];
      iss_rs1    = rs1_q[sel];
      iss_rs2    = rs2_q[sel];
      iss_rd     = rd_q[sel];
      iss_imm    = imm_q[sel];
      iss_exec   = exec_q[sel];
    end
  end

endmodule

// File: tb/tb_dispatch_sequencer.sv
// Directed testbench for dispatch_sequencer: one task per scenario, inline
// comparisons against hand-derived slot order, tags and latencies.
module tb_dispatch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        grp_valid = 1'b0;
  logic        grp_ready;
  logic [3:0]  grp_slot_valid = '0;
  logic [27:0] grp_opcode = '0;
  logic [19:0] grp_rs1 = '0;
  logic [19:0] grp_rs2 = '0;
  logic [19:0] grp_rd = '0;
  logic [127:0] grp_imm = '0;
  logic [15:0] grp_exec = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b1;
  logic [1:0]  iss_slot;
  logic [6:0]  iss_opcode;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [31:0] iss_imm;
  logic [3:0]  iss_exec;
  logic [6:0]  iss_tag;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  dispatch_sequencer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .grp_valid(grp_valid), .grp_ready(grp_ready), .grp_slot_valid(grp_slot_valid),
    .grp_opcode(grp_opcode), .grp_rs1(grp_rs1), .grp_rs2(grp_rs2), .grp_rd(grp_rd),
    .grp_imm(grp_imm), .grp_exec(grp_exec),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_slot(iss_slot),
    .iss_opcode(iss_opcode), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_imm(iss_imm), .iss_exec(iss_exec), .iss_tag(iss_tag), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [57:0] data_bus;
  logic [67:0] issue_bus;
  assign data_bus  = {iss_opcode, iss_rs1, iss_rs2, iss_rd, iss_imm, iss_exec};
  assign issue_bus = {iss_valid, iss_slot, iss_tag, data_bus};

  // Per-slot payload: every field is distinct per slot so a wrong select shows.
  function automatic logic [57:0] exp_data(input int slot);
    return {7'(32 + slot), 5'(slot + 1), 5'(slot + 5), 5'(slot + 9),
            32'hA000_0000 + 32'(slot), 4'(slot + 1)};
  endfunction

  function automatic logic [67:0] exp_issue(input int slot, input int tag);
    return {1'b1, 2'(slot), 7'(tag), exp_data(slot)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; grp_valid = 1'b0; iss_ready = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  // Presents a group for one cycle; grp_ready is expected high on entry.
  task automatic send_group(input logic [3:0] m, input string name);
    grp_valid = 1'b1;
    grp_slot_valid = m;
    for (int i = 0; i < 4; i++) begin
      grp_opcode[i*7 +: 7]   = 7'(32 + i);
      grp_rs1[i*5 +: 5]      = 5'(i + 1);
      grp_rs2[i*5 +: 5]      = 5'(i + 5);
      grp_rd[i*5 +: 5]       = 5'(i + 9);
      grp_imm[i*32 +: 32]    = 32'hA000_0000 + 32'(i);
      grp_exec[i*4 +: 4]     = 4'(i + 1);
    end
    #1;
    checks++;
    if (grp_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept: grp_ready=%b expected 1", name, grp_ready);
    end
    step();
    grp_valid = 1'b0;
    grp_slot_valid = '0;
    #1;
  endtask

  task automatic expect_issue(input string name, input int slot, input int tag);
    checks++;
    if (issue_bus !== exp_issue(slot, tag)) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, issue_bus, exp_issue(slot, tag));
    end
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if ({iss_valid, grp_ready, data_bus} !== {1'b0, 1'b1, 58'd0}) begin
      failures++;
      $display("FAIL %s: iss_valid=%b grp_ready=%b data=%h expected 0/1/0",
               name, iss_valid, grp_ready, data_bus);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; grp_valid = 1'b1; grp_slot_valid = 4'hF;
    step();
    checks++;
    if ({iss_valid, grp_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_hold: iss_valid=%b grp_ready=%b expected 0 0", iss_valid, grp_ready);
    end
    grp_valid = 1'b0; grp_slot_valid = '0;
    rst = 1'b0;
    #1;
    expect_idle("reset_release");
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_full_group();
    do_reset();
    send_group(4'b1111, "full");
    for (int i = 0; i < 4; i++) begin
      expect_issue($sformatf("full_slot%0d", i), i, i);
      step();
    end
    expect_idle("full_done");
  endtask

  task automatic test_sparse();
    do_reset();
    send_group(4'b1010, "sparse");
    expect_issue("sparse_first", 1, 0);
    step();
    expect_issue("sparse_second", 3, 1);
    step();
    expect_idle("sparse_done");
  endtask

  task automatic test_empty_mask();
    // Tag is 2 from the sparse group; an empty group must not consume one.
    send_group(4'b0000, "empty");
    expect_idle("empty_next");
    send_group(4'b0001, "after_empty");
    expect_issue("after_empty_tag", 0, 2);
    step();
    expect_idle("after_empty_done");
  endtask

  task automatic test_stall();
    do_reset();
    send_group(4'b1111, "stall");
    iss_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      expect_issue($sformatf("stall_hold%0d", c), 0, 0);
      step();
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
    end
    iss_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      expect_issue($sformatf("stall_resume%0d", i), i, i);
      step();
    end
    expect_idle("stall_done");
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL stall_cnt_after: got %0d expected 3", stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    send_group(4'b1111, "flush");
    expect_issue("flush_slot0", 0, 0);
    step();
    expect_issue("flush_slot1", 1, 1);
    step();
    flush = 1'b1;
    #1;
    checks++;
    if ({iss_valid, grp_ready} !== 2'b00) begin
      failures++;
      $display("FAIL flush_comb: iss_valid=%b grp_ready=%b expected 0 0", iss_valid, grp_ready);
    end
    step();
    flush = 1'b0;
    #1;
    expect_idle("flush_idle");
    // Flush in IDLE with a group offered must not capture it.
    flush = 1'b1; grp_valid = 1'b1; grp_slot_valid = 4'hF;
    step();
    flush = 1'b0; grp_valid = 1'b0; grp_slot_valid = '0;
    #1;
    expect_idle("flush_blocks_capture");
    send_group(4'b0001, "after_flush");
    expect_issue("after_flush_tag", 0, 2);
    step();
    expect_idle("after_flush_done");
  endtask

  task automatic test_tag_wrap();
    do_reset();
    for (int n = 0; n < 130; n++) begin
      send_group(4'(1 << (n % 4)), "wrap");
      expect_issue($sformatf("wrap_group%0d", n), n % 4, n % 128);
      step();
    end
    expect_idle("wrap_done");
  endtask

  task automatic test_reset_in_issue();
    send_group(4'b1111, "rst_issue");
    iss_ready = 1'b0;
    step();
    checks++;
    if (stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rst_issue_stall: got %0d expected 1", stall_cnt);
    end
    rst = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if ({iss_valid, grp_ready} !== 2'b00) begin
      failures++;
      $display("FAIL rst_issue_comb: iss_valid=%b grp_ready=%b expected 0 0", iss_valid, grp_ready);
    end
    step();
    rst = 1'b0; flush = 1'b0; iss_ready = 1'b1;
    #1;
    expect_idle("rst_issue_idle");
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_issue_stall_clear: got %0d expected 0", stall_cnt);
    end
    send_group(4'b0100, "post_rst");
    expect_issue("post_rst_tag", 2, 0);
    step();
    expect_idle("post_rst_done");
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_sparse();
    test_empty_mask();
    test_stall();
    test_flush();
    test_tag_wrap();
    test_reset_in_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_sequencer.md
DISPATCH_SEQUENCER -- requirements
Module: dispatch_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; ports clk and rst.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- IPC, 4, instruction slots per decoded group
- OPCODE_WIDTH, 7, opcode width
- RF_WIDTH, 5, register index width
- DATA_WIDTH, 32, immediate width
- EXEC_WIDTH, 4, execution ID width
- TAG_WIDTH, 7, issue tag width
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, synchronous active-high reset
- flush, in, 1, discard buffered group
- grp_valid, in, 1, decoded group present
- grp_ready, out, 1, block accepts a group
- grp_slot_valid, in, IPC, per-slot valid (RType|IType|SType)
- grp_opcode, in, IPC*OPCODE_WIDTH, packed per slot, slot i at [i*W +: W]
- grp_rs1 / grp_rs2 / grp_rd, in, IPC*RF_WIDTH each, packed per slot
- grp_imm, in, IPC*DATA_WIDTH, packed per slot
- grp_exec, in, IPC*EXEC_WIDTH, packed per slot
- iss_valid, out, 1, issue offer
- iss_ready, in, 1, consumer accepts the offer
- iss_slot, out, 2 (log2 IPC), slot index being issued
- iss_opcode / iss_rs1 / iss_rs2 / iss_rd / iss_imm / iss_exec, out, per-slot widths, fields of the issued slot
- iss_tag, out, TAG_WIDTH, tag of the issued instruction
- stall_cnt, out, 16, cycles with iss_valid=1 and iss_ready=0

Function
REQ-004 The block SHALL implement a two-state FSM, IDLE and ISSUE.
REQ-005 grp_ready SHALL be 1 only in IDLE with rst=0 and flush=0.
REQ-006 On grp_valid & grp_ready, the block SHALL register all group fields and grp_slot_valid into a pending mask.
- Mask nonzero: go to ISSUE next cycle.
- Mask zero: discard the group and stay IDLE.
REQ-007 In ISSUE, iss_valid SHALL be 1 and the iss_* fields SHALL show the lowest-index set bit of the pending mask; slot 0 is the oldest.
REQ-008 On iss_valid & iss_ready, the block SHALL:
- clear that mask bit;
- increment the tag counter modulo 2^TAG_WIDTH;
- go to IDLE if this was the last set bit, otherwise offer the next set bit in the following cycle.
REQ-009 While iss_valid=1 and iss_ready=0, all iss_* outputs SHALL hold stable.
REQ-010 iss_tag SHALL equal the tag counter value; the counter wraps from 2^TAG_WIDTH-1 to 0.
REQ-011 Latency: a group accepted in cycle N SHALL be first offered in cycle N+1; with iss_ready held at 1, a group with k valid slots SHALL give iss_valid in cycles N+1..N+k and grp_ready in cycle N+k+1.
REQ-012 Slots with grp_slot_valid=0 SHALL never be issued and SHALL NOT consume a tag or a cycle.
REQ-013 flush=1 SHALL force iss_valid=0 and grp_ready=0 combinationally in that cycle.
REQ-014 flush=1 SHALL clear the pending mask and go to IDLE next cycle; it overrides capture and issue in the same cycle, and the tag counter is unchanged.
REQ-015 stall_cnt SHALL increment in each cycle with iss_valid=1 and iss_ready=0, and SHALL saturate at 16'hFFFF.
REQ-016 iss_* data outputs SHALL be 0 whenever iss_valid=0.

Reset
REQ-017 With rst=1 at a clock edge, the block SHALL enter IDLE and clear the mask, the tag counter and stall_cnt to 0.
REQ-018 While rst=1, iss_valid=0 and grp_ready=0.
REQ-019 Reset mid-ISSUE SHALL discard the buffered group with no further issue.
REQ-020 Reset SHALL take priority over flush and all handshakes.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Full group, mask 4'b1111, iss_ready=1 -> slots 0,1,2,3 issued with tags 0,1,2,3 in cycles N+1..N+4; grp_ready=1 at N+5.
- Sparse mask 4'b1010 -> only slots 1 then 3 issued, consecutive cycles, tags 0,1.
- Mask 4'b0000 -> no iss_valid; grp_ready stays 1 the next cycle.
- iss_ready low 3 cycles on slot 0 -> fields stable, stall_cnt=3, then issue resumes with the same tag.
- flush during slot 2 of 4'b1111 -> iss_valid=0 that cycle, IDLE next cycle, next group's first tag=2.
- 130 single-slot groups -> tag wraps 127->0; rst in ISSUE -> tag 0, stall_cnt 0, iss_valid 0.
